// File: rtl/vga_timing_pipe.sv
// Parametrised VGA/XGA timing generator with a display-stage delay line.
// Pixel coordinates are issued PIPE_LAT cycles ahead of the display stage.
// This lets a pipelined colour source line up with the blanking and sync outputs.
module vga_timing_pipe #(
    parameter int unsigned COLOR_DEPTH = 8,
    parameter int unsigned H_ACTIVE    = 1024,
    parameter int unsigned H_FRONT     = 24,
    parameter int unsigned H_SYNC      = 136,
    parameter int unsigned H_BACK      = 160,
    parameter int unsigned V_ACTIVE    = 768,
    parameter int unsigned V_FRONT     = 3,
    parameter int unsigned V_SYNC      = 6,
    parameter int unsigned V_BACK      = 29,
    parameter bit          H_SYNC_POL  = 1'b0,
    parameter bit          V_SYNC_POL  = 1'b0,
    parameter int unsigned PIPE_LAT    = 2,
    parameter int unsigned SCALE_LOG2  = 0,
    parameter int unsigned FRAME_CNT_W = 16
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      enable,
    input  logic [3*COLOR_DEPTH-1:0]                  rgb_in,
    output logic [$clog2(H_ACTIVE>>SCALE_LOG2)-1:0]   x_pixel,
    output logic [$clog2(V_ACTIVE>>SCALE_LOG2)-1:0]   y_pixel,
    output logic                                      pix_req,
    output logic [COLOR_DEPTH-1:0]                    vga_r_out,
    output logic [COLOR_DEPTH-1:0]                    vga_g_out,
    output logic [COLOR_DEPTH-1:0]                    vga_b_out,
    output logic                                      vga_clk,
    output logic                                      vga_blank_n,
    output logic                                      vga_sync_n,
    output logic                                      vga_hs,
    output logic                                      vga_vs,
    output logic                                      line_start,
    output logic                                      frame_start,
    output logic                                      refresh,
    output logic [FRAME_CNT_W-1:0]                    frame_count,
    output logic                                      running
);

    localparam int unsigned XW       = $clog2(H_ACTIVE >> SCALE_LOG2);
    localparam int unsigned YW       = $clog2(V_ACTIVE >> SCALE_LOG2);
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    // Per-position control bits; hs/vs are "sync active", polarity is applied at the pins.
    typedef struct packed {
        logic blank_n;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
        logic rf;
    } ctl_t;

    logic [HW-1:0] ctr_h_q, ctr_h_d;
    logic [VW-1:0] ctr_v_q, ctr_v_d;
    logic          running_q, running_d;
    logic          h_last, v_last, h_act, v_act;

    ctl_t          ctl_d;
    ctl_t          pipe_q [PIPE_LAT+1];
    ctl_t          last;
    logic [XW-1:0] x_d, x_q;
    logic [YW-1:0] y_d, y_q;

    logic                   blank_q, hs_q, vs_q, ls_q, fs_q, rf_q;
    logic [COLOR_DEPTH-1:0] r_q, g_q, b_q;
    logic [FRAME_CNT_W-1:0] fc_q;

    assign h_last = (32'(ctr_h_q) == H_TOTAL - 1);
    assign v_last = (32'(ctr_v_q) == V_TOTAL - 1);
    assign h_act  = (32'(ctr_h_q) < H_ACTIVE);
    assign v_act  = (32'(ctr_v_q) < V_ACTIVE);

    // Counter advance and run control; a stop request only takes effect at the frame wrap.
    always_comb begin
        ctr_h_d   = ctr_h_q;
        ctr_v_d   = ctr_v_q;
        running_d = running_q;
        if (!running_q) begin
            ctr_h_d   = '0;
            ctr_v_d   = '0;
            running_d = enable;
        end else if (h_last) begin
            ctr_h_d = '0;
            if (v_last) begin
                ctr_v_d   = '0;
                running_d = enable;
            end else begin
                ctr_v_d = ctr_v_q + 1'b1;
            end
        end else begin
            ctr_h_d = ctr_h_q + 1'b1;
        end
    end

    // Control bits and coordinates for the current counter position.
    always_comb begin
        ctl_d.blank_n = running_q & h_act & v_act;
        ctl_d.hs      = running_q & (32'(ctr_h_q) >= HS_START) & (32'(ctr_h_q) < HS_END);
        ctl_d.vs      = running_q & (32'(ctr_v_q) >= VS_START) & (32'(ctr_v_q) < VS_END);
        ctl_d.ls      = running_q & (ctr_h_q == '0) & v_act;
        ctl_d.fs      = running_q & (ctr_h_q == '0) & (ctr_v_q == '0);
        ctl_d.rf      = running_q & (ctr_h_q == '0) & (32'(ctr_v_q) == V_ACTIVE);
        x_d           = ctl_d.blank_n ? XW'(ctr_h_q >> SCALE_LOG2) : '0;
        y_d           = ctl_d.blank_n ? YW'(ctr_v_q >> SCALE_LOG2) : '0;
    end

    // Counters, run flag, issue stage and the delay line matching the source latency.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctr_h_q   <= '0;
            ctr_v_q   <= '0;
            running_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            for (int unsigned i = 0; i <= PIPE_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            ctr_h_q   <= ctr_h_d;
            ctr_v_q   <= ctr_v_d;
            running_q <= running_d;
            x_q       <= x_d;
            y_q       <= y_d;
            pipe_q[0] <= ctl_d;
            for (int unsigned i = 1; i <= PIPE_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign last = pipe_q[PIPE_LAT];

    // Display register: rgb_in arrives in the same cycle as the last delay stage.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            blank_q <= 1'b0;
            hs_q    <= ~H_SYNC_POL;
            vs_q    <= ~V_SYNC_POL;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            rf_q    <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            fc_q    <= '0;
        end else begin
            blank_q <= last.blank_n;
            hs_q    <= last.hs ? H_SYNC_POL : ~H_SYNC_POL;
            vs_q    <= last.vs ? V_SYNC_POL : ~V_SYNC_POL;
            ls_q    <= last.ls;
            fs_q    <= last.fs;
            rf_q    <= last.rf;
            r_q     <= last.blank_n ? rgb_in[3*COLOR_DEPTH-1:2*COLOR_DEPTH] : '0;
            g_q     <= last.blank_n ? rgb_in[2*COLOR_DEPTH-1:COLOR_DEPTH] : '0;
            b_q     <= last.blank_n ? rgb_in[COLOR_DEPTH-1:0] : '0;
            if (last.fs) begin
                fc_q <= fc_q + 1'b1;
            end
        end
    end

    assign x_pixel     = x_q;
    assign y_pixel     = y_q;
    assign pix_req     = pipe_q[0].blank_n;
    assign vga_r_out   = r_q;
    assign vga_g_out   = g_q;
    assign vga_b_out   = b_q;
    assign vga_clk     = clk;
    assign vga_blank_n = blank_q;
    assign vga_sync_n  = 1'b1;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign refresh     = rf_q;
    assign frame_count = fc_q;
    assign running     = running_q;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Self-checking bench for vga_timing_pipe using a small raster.
// A reference model tracks the linear frame position and predicts every output each cycle.
module tb_vga_timing_pipe;

    localparam int CD = 4;
    localparam int HA = 16, HF = 2, HSY = 3, HB = 3;
    localparam int VA = 8,  VF = 1, VSY = 2, VB = 1;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int FRAME = HT * VT;
    localparam int LAT = 2;
    localparam int SC = 1;
    localparam int FCW = 3;
    localparam bit HPOL = 1'b1;
    localparam bit VPOL = 1'b0;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            enable = 1'b0;
    logic [3*CD-1:0] rgb_in = '0;
    logic [2:0]      x_pixel;
    logic [1:0]      y_pixel;
    logic            pix_req, vga_clk, vga_blank_n, vga_sync_n, vga_hs, vga_vs;
    logic            line_start, frame_start, refresh, running;
    logic [CD-1:0]   vga_r_out, vga_g_out, vga_b_out;
    logic [FCW-1:0]  frame_count;

    vga_timing_pipe #(
        .COLOR_DEPTH(CD), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
        .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL), .PIPE_LAT(LAT), .SCALE_LOG2(SC),
        .FRAME_CNT_W(FCW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .rgb_in(rgb_in),
        .x_pixel(x_pixel), .y_pixel(y_pixel), .pix_req(pix_req),
        .vga_r_out(vga_r_out), .vga_g_out(vga_g_out), .vga_b_out(vga_b_out),
        .vga_clk(vga_clk), .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .line_start(line_start),
        .frame_start(frame_start), .refresh(refresh), .frame_count(frame_count),
        .running(running)
    );

    always #5 clk = ~clk;

    typedef struct {
        int req;
        int x;
        int y;
        int blank;
        int hs;
        int vs;
        int ls;
        int fs;
        int rf;
    } ent_t;

    int   n_chk = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   m_run = 0;
    int   m_pos = 0;
    int   m_fc = 0;
    int   exp_rgb = 0;
    ent_t hist[$];
    ent_t exp_iss;
    ent_t exp_disp;

    // What the issue stage should show for a given run flag and frame position.
    function automatic ent_t make_ent(input int run, input int pos);
        ent_t e;
        int h, v, act;
        h = pos % HT;
        v = pos / HT;
        act = (run != 0 && h < HA && v < VA) ? 1 : 0;
        e.req   = act;
        e.blank = act;
        e.x     = act ? (h >> SC) : 0;
        e.y     = act ? (v >> SC) : 0;
        e.hs    = (run != 0 && h >= HA + HF && h < HA + HF + HSY) ? 1 : 0;
        e.vs    = (run != 0 && v >= VA + VF && v < VA + VF + VSY) ? 1 : 0;
        e.ls    = (run != 0 && h == 0 && v < VA) ? 1 : 0;
        e.fs    = (run != 0 && pos == 0) ? 1 : 0;
        e.rf    = (run != 0 && h == 0 && v == VA) ? 1 : 0;
        return e;
    endfunction

    task automatic model_edge();
        ent_t e;
        if (!reset_n) begin
            m_run = 0;
            m_pos = 0;
            m_fc = 0;
            exp_rgb = 0;
            hist.delete();
            e = make_ent(0, 0);
            for (int i = 0; i <= LAT; i++) hist.push_back(e);
            exp_iss = e;
            exp_disp = e;
        end else begin
            e = make_ent(m_run, m_pos);
            hist.push_back(e);
            exp_disp = hist.pop_front();
            exp_iss = e;
            if (exp_disp.fs != 0) m_fc = (m_fc + 1) % (1 << FCW);
            exp_rgb = exp_disp.blank != 0 ? int'(rgb_in) : 0;
            if (m_run != 0) begin
                if (m_pos == FRAME - 1) begin
                    m_pos = 0;
                    m_run = int'(enable);
                end else begin
                    m_pos++;
                end
            end else begin
                m_run = int'(enable);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("running", 32'(running), m_run);
        chk("pix_req", 32'(pix_req), exp_iss.req);
        chk("x_pixel", 32'(x_pixel), exp_iss.x);
        chk("y_pixel", 32'(y_pixel), exp_iss.y);
        chk("blank_n", 32'(vga_blank_n), exp_disp.blank);
        chk("vga_hs", 32'(vga_hs), (exp_disp.hs != 0) ? HPOL : !HPOL);
        chk("vga_vs", 32'(vga_vs), (exp_disp.vs != 0) ? VPOL : !VPOL);
        chk("line_start", 32'(line_start), exp_disp.ls);
        chk("frame_start", 32'(frame_start), exp_disp.fs);
        chk("refresh", 32'(refresh), exp_disp.rf);
        chk("frame_count", 32'(frame_count), m_fc);
        chk("rgb_out", 32'({vga_r_out, vga_g_out, vga_b_out}), exp_rgb);
        chk("sync_n", 32'(vga_sync_n), 1);
    endtask

    task automatic step();
        rgb_in = 12'($urandom);
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int budget;

        // Reset and idle hold.
        reset_n = 1'b0;
        enable = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (5) step();

        // Continuous run over several frames.
        enable = 1'b1;
        repeat (2 * FRAME + 50) step();

        // Stop request mid-frame: frame completes, then the pipe drains.
        enable = 1'b0;
        repeat (FRAME + 10) step();

        // Short drop of enable that is withdrawn before the wrap.
        enable = 1'b1;
        repeat (50) step();
        enable = 1'b0;
        repeat (20) step();
        enable = 1'b1;
        repeat (FRAME) step();

        // Random run/stop toggling.
        repeat (20) begin
            enable = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 200)) step();
        end

        // Abrupt reset at ctr_h == 3 while running.
        enable = 1'b1;
        budget = 3 * FRAME;
        while (!(m_run != 0 && (m_pos % HT) == 3 && m_pos > HT) && budget > 0) begin
            step();
            budget--;
        end
        chk("reach_h3_timeout", 32'(budget > 0), 1);
        reset_n = 1'b0;
        enable = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (4) step();

        // Restart and run long enough to wrap frame_count.
        enable = 1'b1;
        repeat (9 * FRAME + 20) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
